l2_bank_req_decoder: RTL and testbench
======================================

// Module: l2_bank_req_decoder
// PURPOSE
//  Parametrised, registered successor to the 2->4 one-hot decoder for the L2 cache request path.
//  Decodes a SEL_W-bit bank/way index into a one-hot request to NUM_OUT targets.
//  Carries a DATA_W payload through a 2-entry skid buffer with valid/ready on both sides.
//  Drops and counts out-of-range indices. Sits between the L2 request arbiter and the bank pipes.
// PARAMETERS
//  SEL_W    2           index width
//  NUM_OUT  1<<SEL_W    number of targets; legal range 1..2**SEL_W
//  DATA_W   32          payload width
//  ERR_W    8           width of the saturating drop counter
// PORTS
//  clk        in   1        clock, all state on rising edge
//  rst        in   1        asynchronous, active-high reset
//  in_valid   in   1        upstream request valid
//  in_ready   out  1        upstream may present next request
//  in_sel     in   SEL_W    target index
//  in_data    in   DATA_W   request payload
//  out_valid  out  NUM_OUT  one-hot valid, bit i = request for target i
//  out_ready  in   NUM_OUT  per-target ready
//  out_data   out  DATA_W   payload of the head entry, shared by all targets
//  err_pulse  out  1        1-cycle pulse: an out-of-range request was dropped
//  err_cnt    out  ERR_W    saturating count of dropped requests
// BEHAVIOUR
//  - Reset (async assert, sync deassert by the top): state EMPTY; both entries invalid.
//    out_valid=0, out_data=0, err_pulse=0, err_cnt=0. in_ready=0 while rst=1.
//  - Accept: acc = in_valid & in_ready.
//    in_ready = ~rst & (state!=FULL), decoded from registered state only.
//    in_ready has no combinational path from out_ready.
//  - Range check: sel_ok = (in_sel < NUM_OUT).
//    acc & ~sel_ok: request consumed but not enqueued. Next cycle err_pulse=1.
//    err_cnt += 1, saturating at 2**ERR_W-1.
//  - Decode: the head entry stores onehot = 1<<in_sel at accept.
//    out_valid = {NUM_OUT{head_v}} & head_onehot. out_valid never has more than 1 bit set.
//  - Fire: fire = |(out_valid & out_ready).
//    Readies of non-selected targets are ignored.
//    out_valid/out_data hold stable until fire (AXI-style, no retraction).
//  - Latency: accept at edge N -> out_valid at N+1 (1 cycle) when the buffer was EMPTY,
//    or when the buffer was ONE and fired in the same cycle.
//  - State machine (enq = acc & sel_ok):
//    EMPTY: enq -> ONE (head<=in)
//    ONE:   enq&~fire -> FULL (skid<=in)
//           enq&fire  -> ONE (head<=in)
//           ~enq&fire -> EMPTY
//           else hold
//    FULL:  fire -> ONE (head<=skid)
//           no accept possible (in_ready=0)
//  - Order: strict FIFO. The skid entry is never presented before the head.
//  - Dropped requests in FULL cannot occur (no accept). In EMPTY/ONE, a drop does not change state.
//  - NUM_OUT=1: SEL_W bits are still checked; only in_sel=0 is legal.
//  - Reset mid-operation: all entries are discarded immediately (async).
//    Outputs go to reset values in the same cycle rst asserts. No partial handshake survives.
// TESTING
//  1. Default params: send in_sel=0..3 with out_ready=all 1s.
//     -> out_valid = 0001,0010,0100,1000 on consecutive cycles, 1-cycle latency, data matches.
//  2. Backpressure: out_ready=0, send A(sel=2), B(sel=1).
//     -> in_ready=0 after B; out_valid=0100 with data A held.
//     Raise out_ready[2] -> B is presented (0010); in_ready=1 next cycle.
//  3. Wrong-target ready: head sel=3, out_ready=0111 for 5 cycles -> no fire, out_valid stays 1000.
//  4. NUM_OUT=3, SEL_W=2: send sel=3 -> not enqueued, err_pulse for 1 cycle, err_cnt=1.
//     Following sel=2 -> out_valid=100.
//  5. ERR_W=2: send 5 illegal requests -> err_cnt = 1,2,3,3,3; err_pulse on each.
//  6. FULL state, assert rst mid-cycle.
//     -> out_valid=0, in_ready=0 immediately.
//     After release: EMPTY, in_ready=1; old entries never appear.

Source files
------------

// File: rtl/l2_bank_req_decoder.sv
// rtl/l2_bank_req_decoder.sv - registered index-to-one-hot request decoder with 2-entry skid buffer
module l2_bank_req_decoder #(
    parameter int SEL_W   = 2,
    parameter int NUM_OUT = 1 << SEL_W,
    parameter int DATA_W  = 32,
    parameter int ERR_W   = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [SEL_W-1:0]   in_sel,
    input  logic [DATA_W-1:0]  in_data,
    output logic [NUM_OUT-1:0] out_valid,
    input  logic [NUM_OUT-1:0] out_ready,
    output logic [DATA_W-1:0]  out_data,
    output logic               err_pulse,
    output logic [ERR_W-1:0]   err_cnt
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    // head_onehot_q is kept all-zero whenever the head entry is invalid,
    // so it doubles as the registered out_valid vector.
    logic [NUM_OUT-1:0] head_onehot_q, head_onehot_d;
    logic [DATA_W-1:0]  head_data_q, head_data_d;
    logic [NUM_OUT-1:0] skid_onehot_q, skid_onehot_d;
    logic [DATA_W-1:0]  skid_data_q, skid_data_d;
    logic               err_pulse_q, err_pulse_d;
    logic [ERR_W-1:0]   err_cnt_q, err_cnt_d;

    logic               sel_ok;
    logic [NUM_OUT-1:0] in_onehot;
    logic               acc;
    logic               enq;
    logic               drop;
    logic               fire;

    // Upstream ready depends only on registered state (and reset), never on out_ready.
    assign in_ready  = ~rst & (state_q != ST_FULL);

    assign out_valid = head_onehot_q;
    assign out_data  = head_data_q;
    assign err_pulse = err_pulse_q;
    assign err_cnt   = err_cnt_q;

    // Handshake decode: range check, one-hot conversion, accept and fire.
    always_comb begin
        sel_ok    = (32'(in_sel) < NUM_OUT);
        in_onehot = NUM_OUT'(1) << in_sel;
        acc       = in_valid & in_ready;
        enq       = acc & sel_ok;
        drop      = acc & ~sel_ok;
        // Only the selected target's ready can complete the transfer.
        fire      = |(head_onehot_q & out_ready);
    end

    // Next-state for the buffer FSM, payload entries and the drop counter.
    always_comb begin
        state_d       = state_q;
        head_onehot_d = head_onehot_q;
        head_data_d   = head_data_q;
        skid_onehot_d = skid_onehot_q;
        skid_data_d   = skid_data_q;
        err_pulse_d   = drop;
        err_cnt_d     = err_cnt_q;

        if (drop && (err_cnt_q != {ERR_W{1'b1}})) begin
            err_cnt_d = err_cnt_q + ERR_W'(1);
        end

        case (state_q)
            ST_EMPTY: begin
                if (enq) begin
                    state_d       = ST_ONE;
                    head_onehot_d = in_onehot;
                    head_data_d   = in_data;
                end
            end
            ST_ONE: begin
                if (enq && !fire) begin
                    state_d       = ST_FULL;
                    skid_onehot_d = in_onehot;
                    skid_data_d   = in_data;
                end else if (enq && fire) begin
                    head_onehot_d = in_onehot;
                    head_data_d   = in_data;
                end else if (fire) begin
                    state_d       = ST_EMPTY;
                    head_onehot_d = '0;
                end
            end
            ST_FULL: begin
                // Skid entry moves up only after the head has left: strict FIFO order.
                if (fire) begin
                    state_d       = ST_ONE;
                    head_onehot_d = skid_onehot_q;
                    head_data_d   = skid_data_q;
                    skid_onehot_d = '0;
                end
            end
            default: begin
                state_d       = ST_EMPTY;
                head_onehot_d = '0;
                skid_onehot_d = '0;
            end
        endcase
    end

    // State registers; reset discards both entries immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_EMPTY;
            head_onehot_q <= '0;
            head_data_q   <= '0;
            skid_onehot_q <= '0;
            skid_data_q   <= '0;
            err_pulse_q   <= 1'b0;
            err_cnt_q     <= '0;
        end else begin
            state_q       <= state_d;
            head_onehot_q <= head_onehot_d;
            head_data_q   <= head_data_d;
            skid_onehot_q <= skid_onehot_d;
            skid_data_q   <= skid_data_d;
            err_pulse_q   <= err_pulse_d;
            err_cnt_q     <= err_cnt_d;
        end
    end

endmodule

// File: tb/tb_l2_bank_req_decoder.sv
// tb/tb_l2_bank_req_decoder.sv - self-checking bench for l2_bank_req_decoder
module tb_l2_bank_req_decoder;

    logic        clk = 1'b0;
    logic        rst;

    // Default-parameter instance (4 targets, 8-bit counter)
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_sel;
    logic [31:0] in_data;
    logic [3:0]  out_valid;
    logic [3:0]  out_ready;
    logic [31:0] out_data;
    logic        err_pulse;
    logic [7:0]  err_cnt;

    // Reduced instance (3 targets, 2-bit counter)
    logic        e_in_valid;
    logic        e_in_ready;
    logic [1:0]  e_in_sel;
    logic [31:0] e_in_data;
    logic [2:0]  e_out_valid;
    logic [2:0]  e_out_ready;
    logic [31:0] e_out_data;
    logic        e_err_pulse;
    logic [1:0]  e_err_cnt;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    l2_bank_req_decoder dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_sel(in_sel), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .err_pulse(err_pulse), .err_cnt(err_cnt)
    );

    l2_bank_req_decoder #(.SEL_W(2), .NUM_OUT(3), .DATA_W(32), .ERR_W(2)) dut_e (
        .clk(clk), .rst(rst),
        .in_valid(e_in_valid), .in_ready(e_in_ready), .in_sel(e_in_sel), .in_data(e_in_data),
        .out_valid(e_out_valid), .out_ready(e_out_ready), .out_data(e_out_data),
        .err_pulse(e_err_pulse), .err_cnt(e_err_cnt)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        v;
        logic [1:0]  sel;
        logic [31:0] data;
        logic [3:0]  rdy;
        logic [3:0]  exp_ov;
        logic [31:0] exp_d;
        logic        exp_ir;
    } vec_t;

    vec_t vecs[$];

    // Reference model: per instance a FIFO of up to two (sel,data) entries
    int          m_n     [2];
    logic [1:0]  m_sel   [2][2];
    logic [31:0] m_dat   [2][2];
    int          m_err   [2];
    logic        m_pulse [2];
    int          m_nout  [2];
    int          m_emax  [2];

    logic        rv   [2];
    logic [1:0]  rsel [2];
    logic [31:0] rdat [2];
    logic [3:0]  rrdy [2];

    task automatic model_step();
        for (int k = 0; k < 2; k++) begin
            logic acc, fire, ok;
            acc  = rv[k] && (m_n[k] < 2);
            fire = (m_n[k] > 0) && rrdy[k][m_sel[k][0]];
            ok   = (int'(rsel[k]) < m_nout[k]);
            if (fire) begin
                m_sel[k][0] = m_sel[k][1];
                m_dat[k][0] = m_dat[k][1];
                m_n[k]--;
            end
            if (acc && ok) begin
                m_sel[k][m_n[k]] = rsel[k];
                m_dat[k][m_n[k]] = rdat[k];
                m_n[k]++;
            end
            m_pulse[k] = acc && !ok;
            if (m_pulse[k] && m_err[k] < m_emax[k]) m_err[k]++;
        end
    endtask

    task automatic model_check();
        logic [3:0]  ov [2];
        logic        ir [2];
        logic        ep [2];
        logic [7:0]  ec [2];
        logic [31:0] od [2];
        ov[0] = out_valid;            ov[1] = {1'b0, e_out_valid};
        ir[0] = in_ready;             ir[1] = e_in_ready;
        ep[0] = err_pulse;            ep[1] = e_err_pulse;
        ec[0] = err_cnt;              ec[1] = {6'd0, e_err_cnt};
        od[0] = out_data;             od[1] = e_out_data;
        for (int k = 0; k < 2; k++) begin
            logic [3:0] exp_ov;
            exp_ov = (m_n[k] > 0) ? (4'b0001 << m_sel[k][0]) : 4'b0000;
            chk($sformatf("rnd%0d_out_valid", k), ov[k], exp_ov);
            chk($sformatf("rnd%0d_in_ready", k), ir[k], m_n[k] < 2);
            chk($sformatf("rnd%0d_err_pulse", k), ep[k], m_pulse[k]);
            chk($sformatf("rnd%0d_err_cnt", k), ec[k], m_err[k]);
            if (m_n[k] > 0) chk($sformatf("rnd%0d_out_data", k), od[k], m_dat[k][0]);
        end
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 0; in_sel = 0; in_data = 0; out_ready = 0;
        e_in_valid = 0; e_in_sel = 0; e_in_data = 0; e_out_ready = 0;

        // Basic decode with all ready, then backpressure, then wrong-target ready
        vecs.push_back(vec_t'{1'b1, 2'd0, 32'hA000_0000, 4'hF, 4'b0001, 32'hA000_0000, 1'b1});
        vecs.push_back(vec_t'{1'b1, 2'd1, 32'hA000_0001, 4'hF, 4'b0010, 32'hA000_0001, 1'b1});
        vecs.push_back(vec_t'{1'b1, 2'd2, 32'hA000_0002, 4'hF, 4'b0100, 32'hA000_0002, 1'b1});
        vecs.push_back(vec_t'{1'b1, 2'd3, 32'hA000_0003, 4'hF, 4'b1000, 32'hA000_0003, 1'b1});
        vecs.push_back(vec_t'{1'b0, 2'd0, 32'h0,         4'hF, 4'b0000, 32'h0,         1'b1});
        vecs.push_back(vec_t'{1'b1, 2'd2, 32'hB000_000A, 4'h0, 4'b0100, 32'hB000_000A, 1'b1});
        vecs.push_back(vec_t'{1'b1, 2'd1, 32'hB000_000B, 4'h0, 4'b0100, 32'hB000_000A, 1'b0});
        vecs.push_back(vec_t'{1'b0, 2'd0, 32'h0,         4'h0, 4'b0100, 32'hB000_000A, 1'b0});
        vecs.push_back(vec_t'{1'b0, 2'd0, 32'h0,         4'h4, 4'b0010, 32'hB000_000B, 1'b1});
        vecs.push_back(vec_t'{1'b0, 2'd0, 32'h0,         4'h4, 4'b0010, 32'hB000_000B, 1'b1});
        vecs.push_back(vec_t'{1'b0, 2'd0, 32'h0,         4'h2, 4'b0000, 32'h0,         1'b1});
        vecs.push_back(vec_t'{1'b1, 2'd3, 32'hC000_0003, 4'h0, 4'b1000, 32'hC000_0003, 1'b1});
        for (int i = 0; i < 5; i++)
            vecs.push_back(vec_t'{1'b0, 2'd0, 32'h0,     4'h7, 4'b1000, 32'hC000_0003, 1'b1});
        vecs.push_back(vec_t'{1'b0, 2'd0, 32'h0,         4'h8, 4'b0000, 32'h0,         1'b1});

        // Reset state
        #12;
        chk("rst_in_ready", in_ready, 1'b0);
        chk("rst_out_valid", out_valid, 4'b0);
        chk("rst_out_data", out_data, 32'h0);
        chk("rst_err_pulse", err_pulse, 1'b0);
        chk("rst_err_cnt", err_cnt, 8'h0);
        chk("rst_e_in_ready", e_in_ready, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready", in_ready, 1'b1);

        // Table-driven vectors
        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            in_valid  = vecs[i].v;
            in_sel    = vecs[i].sel;
            in_data   = vecs[i].data;
            out_ready = vecs[i].rdy;
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d_out_valid", i), out_valid, vecs[i].exp_ov);
            chk($sformatf("vec%0d_in_ready", i), in_ready, vecs[i].exp_ir);
            chk($sformatf("vec%0d_err_pulse", i), err_pulse, 1'b0);
            if (vecs[i].exp_ov != 4'b0)
                chk($sformatf("vec%0d_out_data", i), out_data, vecs[i].exp_d);
        end

        // Out-of-range drop then a legal request on the 3-target instance
        @(negedge clk);
        in_valid = 0; out_ready = 0;
        e_in_valid = 1; e_in_sel = 2'd3; e_in_data = 32'hD000_0003;
        @(posedge clk); #1;
        chk("drop_err_pulse", e_err_pulse, 1'b1);
        chk("drop_err_cnt", e_err_cnt, 2'd1);
        chk("drop_out_valid", e_out_valid, 3'b000);
        @(negedge clk);
        e_in_sel = 2'd2; e_in_data = 32'hE000_0002;
        @(posedge clk); #1;
        chk("legal_err_pulse", e_err_pulse, 1'b0);
        chk("legal_out_valid", e_out_valid, 3'b100);
        chk("legal_out_data", e_out_data, 32'hE000_0002);
        chk("legal_err_cnt", e_err_cnt, 2'd1);
        @(negedge clk);
        e_in_valid = 0; e_out_ready = 3'b100;
        @(posedge clk); #1;
        chk("legal_drain", e_out_valid, 3'b000);

        // Counter saturation at 3
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            e_in_valid = 1; e_in_sel = 2'd3; e_out_ready = 3'b000;
            @(posedge clk); #1;
            chk($sformatf("sat%0d_err_pulse", k), e_err_pulse, 1'b1);
            chk($sformatf("sat%0d_err_cnt", k), e_err_cnt, (k + 2 > 3) ? 2'd3 : 2'(k + 2));
            chk($sformatf("sat%0d_out_valid", k), e_out_valid, 3'b000);
        end
        @(negedge clk);
        e_in_valid = 0;
        @(posedge clk); #1;
        chk("sat_pulse_clear", e_err_pulse, 1'b0);
        chk("sat_cnt_hold", e_err_cnt, 2'd3);

        // Fill to FULL, then assert reset mid-cycle
        @(negedge clk);
        in_valid = 1; in_sel = 2'd1; in_data = 32'hF000_0001; out_ready = 4'h0;
        @(negedge clk);
        in_sel = 2'd2; in_data = 32'hF000_0002;
        @(negedge clk);
        in_valid = 0;
        @(posedge clk); #1;
        chk("full_out_valid", out_valid, 4'b0010);
        chk("full_in_ready", in_ready, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        chk("midrst_out_valid", out_valid, 4'b0000);
        chk("midrst_in_ready", in_ready, 1'b0);
        chk("midrst_out_data", out_data, 32'h0);
        chk("midrst_e_err_cnt", e_err_cnt, 2'd0);
        @(negedge clk);
        rst = 1'b0;
        out_ready = 4'hF;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            chk($sformatf("after_rst%0d_in_ready", k), in_ready, 1'b1);
            chk($sformatf("after_rst%0d_out_valid", k), out_valid, 4'b0000);
        end

        // Randomized run on both instances against the reference model
        m_nout[0] = 4;  m_emax[0] = 255;
        m_nout[1] = 3;  m_emax[1] = 3;
        for (int k = 0; k < 2; k++) begin
            m_n[k] = 0; m_err[k] = 0; m_pulse[k] = 1'b0;
            m_sel[k][0] = 0; m_sel[k][1] = 0; m_dat[k][0] = 0; m_dat[k][1] = 0;
        end
        for (int c = 0; c < 800; c++) begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                rv[k]   = ($urandom_range(0, 3) != 0);
                rsel[k] = 2'($urandom_range(0, 3));
                rdat[k] = $urandom;
                rrdy[k] = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom);
            end
            in_valid    = rv[0];  in_sel   = rsel[0]; in_data   = rdat[0]; out_ready   = rrdy[0];
            e_in_valid  = rv[1];  e_in_sel = rsel[1]; e_in_data = rdat[1]; e_out_ready = rrdy[1][2:0];
            rrdy[1][3]  = 1'b0;
            @(posedge clk);
            model_step();
            #1;
            model_check();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
